stopwatch_ctl: RTL and testbench



---
 rtl/stopwatch_ctl.sv | 108 ++++++++++
 tb/tb_stopwatch_ctl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctl.sv
// Stopwatch control and time base: button edge detection, IDLE/RUN/PAUSE
// sequencing, a prescaled increment pulse for the digit chain, and a
// one-cycle clear pulse for the digit registers.
module stopwatch_ctl #(
    parameter int unsigned DIVISOR = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start_stop,
    input  logic clear,
    output logic inc,
    output logic clr_cnt,
    output logic running,
    output logic paused
);

    localparam int unsigned PW = $clog2(DIVISOR);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t        state_q, state_d;
    logic          ss_prev_q, cl_prev_q;
    logic          ss_rise, cl_rise;
    logic [PW-1:0] presc_q, presc_d;
    logic          inc_q, inc_d;
    logic          clr_cnt_q;
    logic          running_q, paused_q;

    // Rising-edge detection of the already-synchronized button levels
    always_comb begin
        ss_rise = start_stop & ~ss_prev_q;
        cl_rise = clear & ~cl_prev_q;
    end

    // Next state and prescaler; clear wins over start/stop, and a wrap on
    // the edge that leaves RUN is not counted (prescaler holds instead)
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        inc_d   = 1'b0;
        if (cl_rise) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ss_rise) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (ss_rise) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        inc_d   = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (ss_rise) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, prescaler, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ss_prev_q <= 1'b1;
            cl_prev_q <= 1'b1;
            inc_q     <= 1'b0;
            clr_cnt_q <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ss_prev_q <= start_stop;
            cl_prev_q <= clear;
            inc_q     <= inc_d;
            clr_cnt_q <= cl_rise;
            running_q <= (state_d == RUN);
            paused_q  <= (state_d == PAUSE);
        end
    end

    assign inc     = inc_q;
    assign clr_cnt = clr_cnt_q;
    assign running = running_q;
    assign paused  = paused_q;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Bench for stopwatch_ctl: two instances (DIVISOR=4 and DIVISOR=2) share the
// same button stimulus and are compared against a cycle-level reference model.
module tb_stopwatch_ctl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic inc_a, clr_a, run_a, pau_a;
    logic inc_b, clr_b, run_b, pau_b;
    logic [3:0] obs_a, obs_b;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctl #(.DIVISOR(4)) dut_a (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .inc(inc_a), .clr_cnt(clr_a), .running(run_a), .paused(pau_a)
    );

    stopwatch_ctl #(.DIVISOR(2)) dut_b (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .inc(inc_b), .clr_cnt(clr_b), .running(run_b), .paused(pau_b)
    );

    assign obs_a = {inc_a, clr_a, run_a, pau_a};
    assign obs_b = {inc_b, clr_b, run_b, pau_b};

    always #5 clk = ~clk;

    // Reference model: count is "RUN cycles elapsed modulo divisor"
    typedef struct packed {
        int st;
        int cnt;
        bit inc;
    } mstep_t;

    int         mdiv [2] = '{4, 2};
    int         m_st [2] = '{M_IDLE, M_IDLE};
    int         m_cnt[2] = '{0, 0};
    logic [3:0] m_out[2] = '{4'b0, 4'b0};
    logic       m_ssp = 1'b1;
    logic       m_clp = 1'b1;
    logic       m_ssr, m_clr;
    mstep_t     nxt[2];

    function automatic mstep_t model_next(int st, int cnt, int div, bit ssr, bit clr_r);
        mstep_t r;
        r.st  = st;
        r.cnt = cnt;
        r.inc = 1'b0;
        if (clr_r) begin
            r.st  = M_IDLE;
            r.cnt = 0;
        end else if (st == M_IDLE) begin
            r.cnt = 0;
            if (ssr) r.st = M_RUN;
        end else if (ssr) begin
            r.st = (st == M_RUN) ? M_PAUSE : M_RUN;
        end else if (st == M_RUN) begin
            r.cnt = (cnt + 1) % div;
            r.inc = (r.cnt == 0);
        end
        return r;
    endfunction

    assign m_ssr = start_stop & ~m_ssp;
    assign m_clr = clear & ~m_clp;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            nxt[k] = model_next(m_st[k], m_cnt[k], mdiv[k], m_ssr, m_clr);
        end
    end

    always @(posedge clk) begin
        m_ssp <= reset ? 1'b1 : start_stop;
        m_clp <= reset ? 1'b1 : clear;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_st[k]  <= M_IDLE;
                m_cnt[k] <= 0;
                m_out[k] <= 4'b0000;
            end else begin
                m_st[k]  <= nxt[k].st;
                m_cnt[k] <= nxt[k].cnt;
                m_out[k] <= {nxt[k].inc, m_clr, nxt[k].st == M_RUN, nxt[k].st == M_PAUSE};
            end
        end
    end

    // Drive one cycle of inputs at a falling edge, return at the next falling edge
    task automatic tick(input bit ss, input bit cl, input bit rst);
        start_stop = ss;
        clear      = cl;
        reset      = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            n_tests++;
            if ({obs_a, obs_b} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset: got %b exp %b", {obs_a, obs_b}, 8'h00);
            end
        end
    endtask

    task automatic test_run_pulses();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_a !== 4'b0010) begin
            n_fail++;
            $display("FAIL run_start: got %b exp %b", obs_a, 4'b0010);
        end
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({inc_a, run_a, pau_a} !== {(k % 4) == 0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL run_pulse k=%0d: got inc/run/pau %b exp %b", k,
                         {inc_a, run_a, pau_a}, {(k % 4) == 0, 1'b1, 1'b0});
            end
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL run_model k=%0d: got %b exp %b", k, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
    endtask

    task automatic test_pause_resume();
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_a !== 4'b0001) begin
            n_fail++;
            $display("FAIL pause_enter: got %b exp %b", obs_a, 4'b0001);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_a !== 4'b0001) begin
                n_fail++;
                $display("FAIL pause_hold i=%0d: got %b exp %b", i, obs_a, 4'b0001);
            end
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL pause_model i=%0d: got %b exp %b", i, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_a !== 4'b0010) begin
            n_fail++;
            $display("FAIL resume: got %b exp %b", obs_a, 4'b0010);
        end
        // Paused with two RUN cycles elapsed: two more cycles reach the wrap
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (inc_a !== ((k % 4) == 2)) begin
                n_fail++;
                $display("FAIL resume_inc k=%0d: got %b exp %b", k, inc_a, (k % 4) == 2);
            end
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL resume_model k=%0d: got %b exp %b", k, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
    endtask

    task automatic test_clear();
        // Prescaler sits at DIVISOR-1 here, so this clear lands on a wrap edge
        tick(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs_a !== 4'b0100) begin
            n_fail++;
            $display("FAIL clear_run: got %b exp %b", obs_a, 4'b0100);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_one_cycle: got %b exp %b", obs_a, 4'b0000);
        end
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (inc_a !== (k == 4)) begin
                n_fail++;
                $display("FAIL clear_restart k=%0d: got %b exp %b", k, inc_a, k == 4);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            n_tests++;
            if (obs_a !== 4'b0100) begin
                n_fail++;
                $display("FAIL clear_pulse i=%0d: got %b exp %b", i, obs_a, 4'b0100);
            end
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL clear_model i=%0d: got %b exp %b", i, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
    endtask

    task automatic test_hold_through_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if ({obs_a, obs_b} !== 8'h00) begin
                n_fail++;
                $display("FAIL hold_idle i=%0d: got %b exp %b", i, {obs_a, obs_b}, 8'h00);
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({run_a, run_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_then_press: got %b exp %b", {run_a, run_b}, 2'b11);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({obs_a, obs_b} !== 8'b0100_0100) begin
            n_fail++;
            $display("FAIL both_edges: got %b exp %b", {obs_a, obs_b}, 8'b0100_0100);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        // Next edge would wrap the DIVISOR=4 prescaler; reset must suppress it
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, i < 2);
            n_tests++;
            if ({obs_a, obs_b} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_midrun i=%0d: got %b exp %b", i, {obs_a, obs_b}, 8'h00);
            end
        end
    endtask

    task automatic test_div2();
        int cnt;
        int adj;
        bit prev;
        cnt  = 0;
        adj  = 0;
        prev = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (inc_b) cnt++;
            if (inc_b && prev) adj++;
            prev = inc_b;
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL div2_model k=%0d: got %b exp %b", k, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
        n_tests++;
        if (cnt !== 50 || adj !== 0) begin
            n_fail++;
            $display("FAIL div2_count: got %0d pulses %0d adjacent exp 50 pulses 0 adjacent", cnt, adj);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_b !== 4'b0001) begin
            n_fail++;
            $display("FAIL div2_pause_on_wrap: got %b exp %b", obs_b, 4'b0001);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_b !== 4'b0010) begin
            n_fail++;
            $display("FAIL div2_resume: got %b exp %b", obs_b, 4'b0010);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs_b !== 4'b1010) begin
            n_fail++;
            $display("FAIL div2_deferred_inc: got %b exp %b", obs_b, 4'b1010);
        end
    endtask

    task automatic test_random();
        bit ss, cl, rst;
        ss = 1'b0;
        cl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) ss = ~ss;
            if ($urandom_range(0, 11) == 0) cl = ~cl;
            rst = ($urandom_range(0, 99) == 0);
            tick(ss, cl, rst);
            n_tests++;
            if ({obs_a, obs_b} !== {m_out[0], m_out[1]}) begin
                n_fail++;
                $display("FAIL random i=%0d: got %b exp %b", i, {obs_a, obs_b}, {m_out[0], m_out[1]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_pulses();
        test_pause_resume();
        test_clear();
        test_hold_through_reset();
        test_back_to_back();
        test_div2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
